dsp_scaler_capture: RTL and testbench
=====================================

DSP_SCALER_CAPTURE -- requirements
Module: dsp_scaler_capture

Interface
REQ-001 SHALL have parameter MODE, default "NORMAL"; "NORMAL" means count_valid_in is a 1-cycle flag, and "ACKNOWLEDGE" means count_valid_in is a level that is held until acknowledged.
REQ-002 SHALL have parameter AVG_LOG2, default 4, legal range 0..7; it sets the averaging window to 2^AVG_LOG2 samples.
REQ-003 SHALL have clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have count_in, input, 25 bits: interval count from the upstream timed counter.
REQ-006 SHALL have count_valid_in, input, 1 bit: count_in is valid.
REQ-007 SHALL have ack_out, output, 1 bit: acknowledge/restart pulse that drives the upstream counter's rst.
REQ-008 SHALL have cnt_tdata, output, 25 bits: captured count on an AXI4-Stream-style output.
REQ-009 SHALL have cnt_tvalid, input cnt_tready, 1 bit each: output stream handshake.
REQ-010 SHALL have max_out, output, 25 bits: largest count since the last clear.
REQ-011 SHALL have avg_out, output, 25 bits, and avg_valid, output, 1 bit: windowed mean and its 1-cycle strobe.
REQ-012 SHALL have drop_count, output, 8 bits: saturating count of samples dropped from the stream.
REQ-013 SHALL have stat_clr, input, 1 bit: synchronous clear of max, accumulator, sample counter and drop_count.

Function
REQ-014 SHALL implement a capture FSM with states IDLE, ACK and ACK_WAIT.
- NORMAL: stays in IDLE permanently.
- NORMAL: a capture event is any cycle with count_valid_in=1.
REQ-015 In ACKNOWLEDGE mode, the FSM SHALL behave as follows.
- Capture event: IDLE with count_valid_in=1.
- IDLE->ACK on a capture event.
- ACK drives ack_out=1 for exactly one cycle, then goes ->ACK_WAIT.
- ACK_WAIT->IDLE on the first cycle with count_valid_in=0.
- count_valid_in held high during ACK/ACK_WAIT SHALL NOT cause a capture.
REQ-016 ack_out SHALL be registered; it is high in the cycle after the capture event and is 0 at all times in NORMAL mode.
REQ-017 On a capture event, count_in SHALL be registered into cnt_tdata and cnt_tvalid SHALL be 1 on the next cycle (1-cycle latency).
REQ-018 cnt_tvalid SHALL hold, with cnt_tdata stable, until a cycle with cnt_tready=1; it then falls unless a new capture reloads it in the same cycle.
REQ-019 A capture event while cnt_tvalid=1 and cnt_tready=0 SHALL be handled as follows.
- The new sample is dropped from the stream; cnt_tdata is unchanged.
- drop_count increments, saturating at 255.
- max/avg still include the sample.
REQ-020 A capture event in the same cycle as a cnt_tvalid&cnt_tready handshake SHALL load the new sample with no drop.
REQ-021 max_out SHALL update to max(max_out, count_in), unsigned, on the cycle after each capture event.
REQ-022 The accumulator SHALL be 25+AVG_LOG2 bits wide and SHALL sum each captured count, with a sample counter modulo 2^AVG_LOG2.
REQ-023 On the capture that completes the window, the block SHALL do the following.
- avg_out = (accumulated sum including this sample) >> AVG_LOG2, truncated.
- avg_valid is 1 for one cycle, at the cycle after the capture.
- The accumulator and sample counter clear.
- avg_out holds until the next window completes.
REQ-024 AVG_LOG2=0 SHALL give avg_out=count_in and avg_valid on every capture.
REQ-025 stat_clr SHALL take priority over a simultaneous capture for statistics.
- max_out, accumulator, sample counter and drop_count go to 0.
- That sample is not counted in the statistics and produces no avg_valid.
- Stream behaviour is unaffected by stat_clr.
REQ-026 stat_clr SHALL NOT affect the FSM, ack_out or avg_out.
REQ-027 count_in=25'h1000000 (interval-0 case, 2^24) SHALL be handled as an ordinary value in all arithmetic.

Reset
REQ-028 rst_n low SHALL asynchronously force the FSM to IDLE and set every output to 0: ack_out, cnt_tvalid, cnt_tdata, max_out, avg_out, avg_valid, drop_count.
REQ-029 On rst_n low, the accumulator and sample counter SHALL also reset to 0.
REQ-030 Release of rst_n SHALL be synchronous to clk; the first capture can occur on the first clk edge after release.
REQ-031 Reset asserted in ACK or ACK_WAIT SHALL abandon the handshake with no ack_out pulse; a level count_valid_in still high after release SHALL be captured as a new event.

Verification
REQ-032 NORMAL, AVG_LOG2=2, cnt_tready=1: valid pulses with counts 10, 20, 30, 40 -> four stream beats 10, 20, 30, 40; max_out=40; one avg_valid with avg_out=25.
REQ-033 NORMAL, cnt_tready=0: captures 5, 6, 7 -> cnt_tdata stays 5 and drop_count=2; raising cnt_tready while capturing 8 in the same cycle -> beat 5 accepted, then cnt_tdata=8 with no drop increment.
REQ-034 ACKNOWLEDGE: count_valid_in held high for 6 cycles with count 100 -> exactly one capture and one 1-cycle ack_out, FSM in ACK_WAIT until valid falls; a second level capture then succeeds.
REQ-035 stat_clr coincident with capture of 50 after max 80 -> max_out=0 and no stats counted, but the stream beat 50 is delivered; drop_count saturates at 255 after 300 forced drops.
REQ-036 Assert rst_n low in ACK_WAIT with count_valid_in still high -> all outputs 0 immediately; after release, the held valid is captured again and ack_out pulses once.

Source files
------------

// File: rtl/dsp_scaler_capture.sv
// ---------------------------------------------------------------------------
// dsp_scaler_capture
//
// Captures interval counts from an upstream timed counter, forwards them on a
// single-entry AXI4-Stream-style output, and keeps running statistics
// (maximum and a 2^AVG_LOG2-sample windowed mean) over every captured count.
//
// Parameters
//   MODE      "NORMAL"      : count_valid_in is a 1-cycle flag; every cycle
//                             with it high is a capture.
//             "ACKNOWLEDGE" : count_valid_in is a level held until the
//                             upstream counter is restarted through ack_out.
//   AVG_LOG2  0..7, averaging window is 2^AVG_LOG2 captures.
//
// Ports
//   clk             single clock for all logic
//   rst_n           asynchronous active-low reset, released synchronously
//   count_in        interval count (25 bits, 2^24 is an ordinary value)
//   count_valid_in  count_in is valid (pulse or level, see MODE)
//   ack_out         registered restart pulse to the upstream counter
//   cnt_tdata       captured count on the output stream
//   cnt_tvalid      output stream valid
//   cnt_tready      output stream ready
//   max_out         largest count since the last clear
//   avg_out         mean of the last completed window
//   avg_valid       1-cycle strobe when avg_out is updated
//   drop_count      saturating count of captures lost to stream backpressure
//   stat_clr        synchronous clear of max, accumulator, sample counter and
//                   drop_count; the stream and the capture FSM ignore it
// ---------------------------------------------------------------------------
module dsp_scaler_capture #(
    parameter string MODE     = "NORMAL",
    parameter int    AVG_LOG2 = 4,
    localparam int   DATA_W   = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] count_in,
    input  logic              count_valid_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] cnt_tdata,
    output logic              cnt_tvalid,
    input  logic              cnt_tready,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic [7:0]        drop_count,
    input  logic              stat_clr
);

    localparam bit ACK_MODE = (MODE == "ACKNOWLEDGE");

    // The accumulator must hold the sum of a full window without wrapping.
    localparam int ACC_W  = DATA_W + AVG_LOG2;

    // A zero-width sample counter is not legal, so AVG_LOG2=0 keeps one bit
    // that never leaves 0 (every capture completes the window).
    localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        ACK_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              capture_p0;
    logic              stream_free_p0;
    logic              drop_p0;
    logic              win_done_p0;
    logic [ACC_W-1:0]  acc_sum_p0;

    logic [ACC_W-1:0]  acc;
    logic [SCNT_W-1:0] scnt;

    // Drop counter saturates rather than wrapping so a long stall is visible.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Window mean: the sum of 2^AVG_LOG2 samples shifted down, truncated.
    function automatic logic [DATA_W-1:0] window_mean(input logic [ACC_W-1:0] s);
        return DATA_W'(s >> AVG_LOG2);
    endfunction

    // ---- stage p0: capture decision (combinational on this cycle's inputs)
    always_comb begin
        state_nxt  = state;
        capture_p0 = 1'b0;
        if (!ACK_MODE) begin
            state_nxt  = IDLE;
            capture_p0 = count_valid_in;
        end else begin
            case (state)
                IDLE: begin
                    if (count_valid_in) begin
                        capture_p0 = 1'b1;
                        state_nxt  = ACK;
                    end
                end
                ACK: begin
                    state_nxt = ACK_WAIT;
                end
                ACK_WAIT: begin
                    // The upstream counter drops its level once it has seen
                    // the restart; only then may a new level be captured.
                    if (!count_valid_in) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // The single output slot is free when empty or being drained this cycle,
    // which lets a capture coincide with a handshake without dropping.
    assign stream_free_p0 = !cnt_tvalid || cnt_tready;
    assign drop_p0        = capture_p0 && !stream_free_p0;

    assign acc_sum_p0  = acc + ACC_W'(count_in);
    assign win_done_p0 = (scnt == SCNT_LAST);

    // ---- stage p1: registered results, visible the cycle after capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ack_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            ack_out <= ACK_MODE && capture_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_tvalid <= 1'b0;
            cnt_tdata  <= '0;
        end else if (capture_p0 && stream_free_p0) begin
            cnt_tvalid <= 1'b1;
            cnt_tdata  <= count_in;
        end else if (cnt_tready) begin
            cnt_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (stat_clr) begin
            drop_count <= '0;
        end else if (drop_p0) begin
            drop_count <= sat_inc8(drop_count);
        end
    end

    // Statistics see every capture, including ones dropped from the stream.
    // stat_clr wins over a coincident capture, and leaves avg_out untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_out   <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            acc       <= '0;
            scnt      <= '0;
        end else if (stat_clr) begin
            max_out   <= '0;
            avg_valid <= 1'b0;
            acc       <= '0;
            scnt      <= '0;
        end else begin
            avg_valid <= 1'b0;
            if (capture_p0) begin
                if (count_in > max_out) begin
                    max_out <= count_in;
                end
                if (win_done_p0) begin
                    avg_out   <= window_mean(acc_sum_p0);
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    scnt      <= '0;
                end else begin
                    acc  <= acc_sum_p0;
                    scnt <= scnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_scaler_capture.sv
// ---------------------------------------------------------------------------
// tb_dsp_scaler_capture
//
// Three instances share one stimulus stream:
//   u0 : NORMAL,      AVG_LOG2=2
//   u1 : ACKNOWLEDGE, AVG_LOG2=2
//   u2 : NORMAL,      AVG_LOG2=0
// A behavioural model predicts every output of every instance each cycle;
// directed sequences add literal expectations for the documented scenarios,
// followed by a randomized run with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_dsp_scaler_capture;

    localparam int NI = 3;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic [24:0] count_in = '0;
    logic        valid    = 1'b0;
    logic        tready   = 1'b0;
    logic        clr      = 1'b0;

    logic        ack    [NI];
    logic [24:0] tdata  [NI];
    logic        tvalid [NI];
    logic [24:0] maxo   [NI];
    logic [24:0] avgo   [NI];
    logic        avgv   [NI];
    logic [7:0]  drop   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dsp_scaler_capture #(.MODE("NORMAL"), .AVG_LOG2(2)) u0 (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_valid_in(valid),
        .ack_out(ack[0]), .cnt_tdata(tdata[0]), .cnt_tvalid(tvalid[0]),
        .cnt_tready(tready), .max_out(maxo[0]), .avg_out(avgo[0]),
        .avg_valid(avgv[0]), .drop_count(drop[0]), .stat_clr(clr));

    dsp_scaler_capture #(.MODE("ACKNOWLEDGE"), .AVG_LOG2(2)) u1 (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_valid_in(valid),
        .ack_out(ack[1]), .cnt_tdata(tdata[1]), .cnt_tvalid(tvalid[1]),
        .cnt_tready(tready), .max_out(maxo[1]), .avg_out(avgo[1]),
        .avg_valid(avgv[1]), .drop_count(drop[1]), .stat_clr(clr));

    dsp_scaler_capture #(.MODE("NORMAL"), .AVG_LOG2(0)) u2 (
        .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_valid_in(valid),
        .ack_out(ack[2]), .cnt_tdata(tdata[2]), .cnt_tvalid(tvalid[2]),
        .cnt_tready(tready), .max_out(maxo[2]), .avg_out(avgo[2]),
        .avg_valid(avgv[2]), .drop_count(drop[2]), .stat_clr(clr));

    function automatic bit ack_of(input int i);
        return (i == 1);
    endfunction

    function automatic int lg_of(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] at %0t: got 0x%0h, expected 0x%0h",
                     nm, inst, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Handshake rule in ACKNOWLEDGE mode: after a capture, a new capture is
    // allowed only once valid has been seen low at least two cycles after it.
    bit          m_pend   [NI];
    bit          m_low    [NI];
    int          m_age    [NI];
    logic        m_ack    [NI];
    logic [24:0] m_tdata  [NI];
    logic        m_tvalid [NI];
    logic [24:0] m_max    [NI];
    logic [24:0] m_avg    [NI];
    logic        m_avgv   [NI];
    int          m_drop   [NI];
    longint      m_sum    [NI];
    int          m_n      [NI];

    always @(posedge clk or negedge rst_n) begin
        bit cap;
        bit dropped;
        int age_now;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_pend[i] = 0; m_low[i] = 0; m_age[i] = 0;
                m_ack[i] = 0; m_tdata[i] = '0; m_tvalid[i] = 0;
                m_max[i] = '0; m_avg[i] = '0; m_avgv[i] = 0;
                m_drop[i] = 0; m_sum[i] = 0; m_n[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                age_now = m_age[i] + 1;
                if (!ack_of(i)) cap = valid;
                else            cap = valid && (!m_pend[i] || m_low[i]);
                if (cap) begin
                    m_pend[i] = 1; m_low[i] = 0; m_age[i] = 0;
                end else begin
                    if (m_pend[i] && age_now >= 2 && !valid) m_low[i] = 1;
                    m_age[i] = age_now;
                end
                m_ack[i] = ack_of(i) && cap;

                dropped = cap && m_tvalid[i] && !tready;
                if (cap && !dropped) begin
                    m_tdata[i]  = count_in;
                    m_tvalid[i] = 1;
                end else if (tready) begin
                    m_tvalid[i] = 0;
                end

                if (clr) begin
                    m_max[i] = '0; m_sum[i] = 0; m_n[i] = 0;
                    m_avgv[i] = 0; m_drop[i] = 0;
                end else begin
                    m_avgv[i] = 0;
                    if (cap) begin
                        if (count_in > m_max[i]) m_max[i] = count_in;
                        m_sum[i] += longint'(count_in);
                        m_n[i]++;
                        if (m_n[i] == (1 << lg_of(i))) begin
                            m_avg[i]  = 25'(m_sum[i] / (longint'(1) << lg_of(i)));
                            m_avgv[i] = 1;
                            m_sum[i]  = 0;
                            m_n[i]    = 0;
                        end
                    end
                    if (dropped && m_drop[i] < 255) m_drop[i]++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk("ack_out",    i, 32'(ack[i]),    32'(m_ack[i]));
            chk("cnt_tvalid", i, 32'(tvalid[i]), 32'(m_tvalid[i]));
            chk("cnt_tdata",  i, 32'(tdata[i]),  32'(m_tdata[i]));
            chk("max_out",    i, 32'(maxo[i]),   32'(m_max[i]));
            chk("avg_out",    i, 32'(avgo[i]),   32'(m_avg[i]));
            chk("avg_valid",  i, 32'(avgv[i]),   32'(m_avgv[i]));
            chk("drop_count", i, 32'(drop[i]),   32'(m_drop[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [24:0] c, input logic v,
                         input logic r, input logic s);
        count_in = c; valid = v; tready = r; clr = s;
        tick();
    endtask

    task automatic all_zero(input string tag, input int i);
        chk({tag, "_ack"},    i, 32'(ack[i]),    32'd0);
        chk({tag, "_tvalid"}, i, 32'(tvalid[i]), 32'd0);
        chk({tag, "_tdata"},  i, 32'(tdata[i]),  32'd0);
        chk({tag, "_max"},    i, 32'(maxo[i]),   32'd0);
        chk({tag, "_avg"},    i, 32'(avgo[i]),   32'd0);
        chk({tag, "_avgv"},   i, 32'(avgv[i]),   32'd0);
        chk({tag, "_drop"},   i, 32'(drop[i]),   32'd0);
    endtask

    initial begin
        int acks;
        int sel;
        logic [24:0] c;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all_zero("rst", 0);
        all_zero("rst", 1);
        rst_n = 1'b1;

        // Four pulses, ready high: beats 10..40, max 40, one mean of 25.
        apply(25'd10, 1, 1, 0);
        chk("p32_tdata10", 0, 32'(tdata[0]), 32'd10);
        chk("p32_tvalid",  0, 32'(tvalid[0]), 32'd1);
        chk("p24_avg",     2, 32'(avgo[2]), 32'd10);
        chk("p24_avgv",    2, 32'(avgv[2]), 32'd1);
        chk("p32_avgv_early", 0, 32'(avgv[0]), 32'd0);
        apply(25'd20, 1, 1, 0);
        chk("p32_tdata20", 0, 32'(tdata[0]), 32'd20);
        apply(25'd30, 1, 1, 0);
        chk("p32_tdata30", 0, 32'(tdata[0]), 32'd30);
        apply(25'd40, 1, 1, 0);
        chk("p32_tdata40", 0, 32'(tdata[0]), 32'd40);
        chk("p32_max",     0, 32'(maxo[0]), 32'd40);
        chk("p32_avg",     0, 32'(avgo[0]), 32'd25);
        chk("p32_avgv",    0, 32'(avgv[0]), 32'd1);
        apply(25'd0, 0, 1, 0);
        chk("p32_avgv_fall", 0, 32'(avgv[0]), 32'd0);
        chk("p32_avg_hold",  0, 32'(avgo[0]), 32'd25);

        // Backpressure drops, then capture coinciding with a handshake.
        apply(25'd0, 0, 1, 1);
        apply(25'd5, 1, 0, 0);
        apply(25'd6, 1, 0, 0);
        apply(25'd7, 1, 0, 0);
        chk("p33_tdata5", 0, 32'(tdata[0]), 32'd5);
        chk("p33_drop2",  0, 32'(drop[0]), 32'd2);
        apply(25'd8, 1, 1, 0);
        chk("p33_tdata8", 0, 32'(tdata[0]), 32'd8);
        chk("p33_tvalid", 0, 32'(tvalid[0]), 32'd1);
        chk("p33_drop_keep", 0, 32'(drop[0]), 32'd2);
        apply(25'd0, 0, 1, 0);

        // stat_clr coincident with a capture, then drop saturation.
        apply(25'd80, 1, 1, 0);
        chk("p35_max80", 0, 32'(maxo[0]), 32'd80);
        apply(25'd50, 1, 1, 1);
        chk("p35_max0",   0, 32'(maxo[0]), 32'd0);
        chk("p35_tdata",  0, 32'(tdata[0]), 32'd50);
        chk("p35_tvalid", 0, 32'(tvalid[0]), 32'd1);
        chk("p35_drop0",  0, 32'(drop[0]), 32'd0);
        for (int k = 0; k < 300; k++) apply(25'(k + 1), 1, 0, 0);
        chk("p35_drop_sat", 0, 32'(drop[0]), 32'd255);
        chk("p35_tdata_hold", 0, 32'(tdata[0]), 32'd50);
        apply(25'd0, 0, 1, 0);
        apply(25'd0, 0, 1, 1);

        // 2^24 treated as an ordinary count.
        apply(25'h1000000, 1, 1, 0);
        chk("p27_max",   0, 32'(maxo[0]), 32'h1000000);
        chk("p27_tdata", 0, 32'(tdata[0]), 32'h1000000);
        repeat (3) apply(25'd0, 0, 1, 0);

        // ACKNOWLEDGE: six-cycle level gives exactly one capture and ack.
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            apply(25'd100, 1, 1, 0);
            if (k == 0) begin
                chk("p34_ack_first", 1, 32'(ack[1]), 32'd1);
                chk("p34_tdata",     1, 32'(tdata[1]), 32'd100);
            end
            acks += int'(ack[1]);
        end
        chk("p34_ack_count", 1, 32'(acks), 32'd1);
        apply(25'd0, 0, 1, 0);
        apply(25'd200, 1, 1, 0);
        chk("p34_second_ack", 1, 32'(ack[1]), 32'd1);
        chk("p34_second_tdata", 1, 32'(tdata[1]), 32'd200);

        // Reset in ACK_WAIT with the level still high.
        apply(25'd200, 1, 1, 0);
        apply(25'd200, 1, 1, 0);
        count_in = 25'd300;
        rst_n = 1'b0;
        #1;
        all_zero("p36_async", 1);
        all_zero("p36_async", 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("p36_recap_ack",   1, 32'(ack[1]), 32'd1);
        chk("p36_recap_tdata", 1, 32'(tdata[1]), 32'd300);
        tick();
        chk("p36_ack_once", 1, 32'(ack[1]), 32'd0);
        apply(25'd0, 0, 1, 0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int k = 0; k < 3000; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       c = 25'($urandom_range(0, 100));
                1:       c = 25'h1000000;
                2:       c = 25'h1FFFFFF;
                default: c = 25'($urandom);
            endcase
            count_in = c;
            valid    = ($urandom_range(0, 9) < 6);
            tready   = ($urandom_range(0, 9) < 7);
            clr      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
